// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared types and constants for the segmented RISC-V core.
//   XLEN        datapath / register width
//   REG_ADDR_W  register index width
//   NREGS       number of architectural integer registers
//   word_t      one XLEN-bit datapath word
//   reg_addr_t  one register index
//   wb_sel_t    writeback source selector (ALU result, load data, link address)
//   wb_select() fixed-priority decode of the WB control bits into wb_sel_t
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef logic [XLEN-1:0]       word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2
  } wb_sel_t;

  // A link write beats a load write when both control bits are set; the
  // combination is not flagged, the jump simply wins.
  function automatic wb_sel_t wb_select(input logic jump_rd, input logic mem_to_reg);
    if (jump_rd)         return WB_PC4;
    else if (mem_to_reg) return WB_MEM;
    else                 return WB_ALU;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// -----------------------------------------------------------------------------
// regfile_2r1w
// Integer register file: two combinational read ports, one synchronous write
// port, register 0 hardwired to zero, write-first bypass on both read ports.
//   clk, rst            core clock, synchronous active-high reset (clears storage)
//   i_we                write enable (a write to index 0 is ignored)
//   i_waddr, i_wdata    write index and data
//   i_raddr1, i_raddr2  read indices
//   o_rdata1, o_rdata2  read data; returns i_wdata when reading the index
//                       being written this cycle
// -----------------------------------------------------------------------------
module regfile_2r1w #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [AW-1:0]   i_raddr1,
  input  logic [AW-1:0]   i_raddr2,
  output logic [XLEN-1:0] o_rdata1,
  output logic [XLEN-1:0] o_rdata2
);

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_wr_active;

  assign w_wr_active = i_we && (i_waddr != '0);

  // NOTE: the storage array is reset explicitly because the architecture
  // requires every register to read zero after reset; this prevents the
  // array from mapping onto a plain RAM macro, which is acceptable at 32x32.
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples its inputs from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_active) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // x0 masking first, then bypass, then storage: an ID-stage read of the
  // register being committed sees the new value in the same cycle.
  assign o_rdata1 = (i_raddr1 == '0)                      ? '0      :
                    (w_wr_active && i_raddr1 == i_waddr)  ? i_wdata :
                                                            r_regs[i_raddr1];

  assign o_rdata2 = (i_raddr2 == '0)                      ? '0      :
                    (w_wr_active && i_raddr2 == i_waddr)  ? i_wdata :
                                                            r_regs[i_raddr2];

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// WB stage of the segmented RISC-V core: picks the writeback value, commits it
// to the integer register file, serves the two ID read ports and counts retired
// instructions.
//   clk, rst                 core clock, synchronous active-high reset
//   WB control:   reg_write_in, jump_rd_in, mem_to_reg_in, wb_valid_in
//   WB payload:   rd_addr_in, alu_result_in, mem_rdata_in, pc_plus4_in
//   ID reads:     rs1_addr, rs2_addr -> rs1_data, rs2_data (combinational)
//   Forwarding:   wb_data (selected value), wb_we (write enable, rd != 0)
//   Counter:      instret (retired instructions, wraps modulo 2^CNT_W)
// -----------------------------------------------------------------------------
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  // WB pipeline register: control
  input  logic             reg_write_in,
  input  logic             jump_rd_in,
  input  logic             mem_to_reg_in,
  input  logic             wb_valid_in,
  // WB pipeline register: payload
  input  logic [4:0]       rd_addr_in,
  input  logic [XLEN-1:0]  alu_result_in,
  input  logic [XLEN-1:0]  mem_rdata_in,
  input  logic [XLEN-1:0]  pc_plus4_in,
  // ID-stage read ports
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  // Forwarding / status
  output logic [XLEN-1:0]  wb_data,
  output logic             wb_we,
  output logic [CNT_W-1:0] instret
);

  wb_sel_t          w_sel;
  logic [CNT_W-1:0] r_instret;

  assign w_sel = wb_select(jump_rd_in, mem_to_reg_in);

  // NOTE: a default is assigned before the case so every path drives wb_data
  // and no latch is inferred for the unused selector encoding.
  always_comb begin
    wb_data = alu_result_in;
    case (w_sel)
      WB_MEM:  wb_data = mem_rdata_in;
      WB_PC4:  wb_data = pc_plus4_in;
      default: wb_data = alu_result_in;
    endcase
  end

  assign wb_we = reg_write_in && (rd_addr_in != '0);

  regfile_2r1w #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .i_we     (wb_we),
    .i_waddr  (rd_addr_in),
    .i_wdata  (wb_data),
    .i_raddr1 (rs1_addr),
    .i_raddr2 (rs2_addr),
    .o_rdata1 (rs1_data),
    .o_rdata2 (rs2_data)
  );

  // Any valid instruction retires, whether or not it writes a register, so
  // stores and branches are counted too. The counter wraps freely.
  always_ff @(posedge clk) begin
    if (rst)              r_instret <= '0;
    else if (wb_valid_in) r_instret <= r_instret + CNT_W'(1);
  end

  assign instret = r_instret;

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Self-checking bench for writeback_stage. A second instance with a 4-bit
// counter shares all inputs so the modulo wrap of instret can be reached in a
// handful of cycles.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        reg_write_in, jump_rd_in, mem_to_reg_in, wb_valid_in;
  logic [4:0]  rd_addr_in, rs1_addr, rs2_addr;
  logic [31:0] alu_result_in, mem_rdata_in, pc_plus4_in;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        wb_we;
  logic [63:0] instret;
  logic [31:0] rs1_data_n, rs2_data_n, wb_data_n;
  logic        wb_we_n;
  logic [3:0]  instret_n;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk(clk), .rst(rst),
    .reg_write_in(reg_write_in), .jump_rd_in(jump_rd_in),
    .mem_to_reg_in(mem_to_reg_in), .wb_valid_in(wb_valid_in),
    .rd_addr_in(rd_addr_in), .alu_result_in(alu_result_in),
    .mem_rdata_in(mem_rdata_in), .pc_plus4_in(pc_plus4_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .instret(instret)
  );

  writeback_stage #(.CNT_W(4)) dut_narrow (
    .clk(clk), .rst(rst),
    .reg_write_in(reg_write_in), .jump_rd_in(jump_rd_in),
    .mem_to_reg_in(mem_to_reg_in), .wb_valid_in(wb_valid_in),
    .rd_addr_in(rd_addr_in), .alu_result_in(alu_result_in),
    .mem_rdata_in(mem_rdata_in), .pc_plus4_in(pc_plus4_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data_n), .rs2_data(rs2_data_n),
    .wb_data(wb_data_n), .wb_we(wb_we_n), .instret(instret_n)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_regs [32];
  logic [63:0] m_instret;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_wb();
    if (jump_rd_in)    return pc_plus4_in;
    if (mem_to_reg_in) return mem_rdata_in;
    return alu_result_in;
  endfunction

  function automatic logic exp_we();
    return reg_write_in && (rd_addr_in != 5'd0);
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0)                     return 32'd0;
    if (exp_we() && a == rd_addr_in)   return exp_wb();
    return m_regs[a];
  endfunction

  // Advance one clock, updating the model with what the DUT commits.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_instret = 64'd0;
    end else begin
      if (exp_we()) m_regs[rd_addr_in] = exp_wb();
      if (wb_valid_in) m_instret = m_instret + 64'd1;
    end
    #1;
  endtask

  task automatic drive(input logic rw, input logic jmp, input logic m2r, input logic vld,
                       input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mrd,
                       input logic [31:0] pc4, input logic [4:0] a1, input logic [4:0] a2);
    reg_write_in  = rw;  jump_rd_in   = jmp; mem_to_reg_in = m2r; wb_valid_in = vld;
    rd_addr_in    = rd;  alu_result_in = alu; mem_rdata_in = mrd; pc_plus4_in = pc4;
    rs1_addr      = a1;  rs2_addr     = a2;
  endtask

  task automatic idle(input logic [4:0] a1, input logic [4:0] a2);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, a1, a2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rw, jmp, m2r, vld;
    logic [4:0]  rd;
    logic [31:0] alu, mrd, pc4;
    logic [4:0]  a1, a2;
    logic [31:0] e_wb;
    logic        e_we;
    logic [31:0] e_r1, e_r2;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n_valid;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0, 32'h0, 5'd5, 5'd0,
                32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'h00000011, 32'h0, 32'h0, 5'd5, 5'd7,
                32'h00000011, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h00000099, 32'h12345678, 32'h0, 5'd7, 5'd7,
                32'h12345678, 1'b1, 32'h12345678, 32'h12345678};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 32'h00000033, 32'h00000044, 32'h00000104, 5'd0, 5'd7,
                32'h00000104, 1'b0, 32'h0, 32'h12345678};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h00000055, 32'h0, 32'h0, 5'd9, 5'd5,
                32'h00000055, 1'b0, 32'h0, 32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 5'd9, 32'h00000066, 32'h0, 32'h00000200, 5'd9, 5'd3,
                32'h00000200, 1'b1, 32'h00000200, 32'h0};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 32'h00000077, 32'h0, 32'h0, 5'd9, 5'd0,
                32'h00000077, 1'b0, 32'h00000200, 32'h0};

    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_instret = 64'd0;

    // --- reset, then every index reads zero ---
    do_reset();
    for (int i = 0; i < 32; i++) begin
      idle(5'(i), 5'(31 - i));
      #1;
      check($sformatf("reset_rs1_x%0d", i), {32'd0, rs1_data}, 64'd0);
      check($sformatf("reset_rs2_x%0d", 31 - i), {32'd0, rs2_data}, 64'd0);
    end
    check("reset_instret", instret, 64'd0);
    check("reset_instret_narrow", {60'd0, instret_n}, 64'd0);

    // --- directed table ---
    n_valid = 0;
    for (int v = 0; v < 7; v++) begin
      drive(vecs[v].rw, vecs[v].jmp, vecs[v].m2r, vecs[v].vld, vecs[v].rd,
            vecs[v].alu, vecs[v].mrd, vecs[v].pc4, vecs[v].a1, vecs[v].a2);
      #1;
      check($sformatf("vec%0d_wb_data", v), {32'd0, wb_data},  {32'd0, vecs[v].e_wb});
      check($sformatf("vec%0d_wb_we", v),   {63'd0, wb_we},    {63'd0, vecs[v].e_we});
      check($sformatf("vec%0d_rs1", v),     {32'd0, rs1_data}, {32'd0, vecs[v].e_r1});
      check($sformatf("vec%0d_rs2", v),     {32'd0, rs2_data}, {32'd0, vecs[v].e_r2});
      if (vecs[v].vld) n_valid++;
      tick();
    end
    idle(5'd0, 5'd0);
    #1;
    check("table_instret", instret, 64'(n_valid));

    // --- retire counting with bubbles, and wrap on the narrow counter ---
    do_reset();
    begin
      logic [12:0] pattern;
      pattern = 13'b1011011101111; // 10 retires, 3 bubbles
      for (int i = 0; i < 13; i++) begin
        idle(5'd0, 5'd0);
        wb_valid_in = pattern[i];
        tick();
      end
    end
    idle(5'd0, 5'd0);
    #1;
    check("instret_after_10", instret, 64'd10);
    check("instret_narrow_after_10", {60'd0, instret_n}, 64'd10);
    for (int i = 0; i < 6; i++) begin
      idle(5'd0, 5'd0);
      wb_valid_in = 1'b1;
      tick();
    end
    idle(5'd0, 5'd0);
    #1;
    check("instret_after_16", instret, 64'd16);
    check("instret_narrow_wrap", {60'd0, instret_n}, 64'd0);

    // --- reset mid-stream discards the concurrent write ---
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 32'h0, 32'h0, 5'd3, 5'd0);
    tick();
    idle(5'd3, 5'd0);
    #1;
    check("x3_written", {32'd0, rs1_data}, 64'h00000000A5A5A5A5);
    rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h00000001, 32'h0, 32'h0, 5'd4, 5'd3);
    #1;
    check("rst_cycle_bypass_x4", {32'd0, rs1_data}, 64'd1);
    tick();
    rst = 1'b0;
    idle(5'd3, 5'd4);
    #1;
    check("post_rst_x3", {32'd0, rs1_data}, 64'd0);
    check("post_rst_x4", {32'd0, rs2_data}, 64'd0);
    check("post_rst_instret", instret, 64'd0);

    // --- randomized traffic against the model ---
    for (int c = 0; c < 400; c++) begin
      logic [4:0] rd;
      rd = 5'($urandom_range(0, 31));
      rst = ($urandom_range(0, 39) == 0);
      drive(1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            rd, $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31)));
      #1;
      check("rnd_wb_data", {32'd0, wb_data},  {32'd0, exp_wb()});
      check("rnd_wb_we",   {63'd0, wb_we},    {63'd0, exp_we()});
      check("rnd_rs1",     {32'd0, rs1_data}, {32'd0, exp_read(rs1_addr)});
      check("rnd_rs2",     {32'd0, rs2_data}, {32'd0, exp_read(rs2_addr)});
      check("rnd_instret", instret, m_instret);
      check("rnd_instret_narrow", {60'd0, instret_n}, {60'd0, m_instret[3:0]});
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
